// File: rtl/instruction_cache_pkg.sv
// rtl/instruction_cache_pkg.sv - shared FSM encoding and width helpers for the instruction cache
package instruction_cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        MISS    = 2'd2,
        HIT     = 2'd3
    } state_t;

    // Width helpers so every module derives identical widths from its parameters.
    function automatic int blk_bits(input int l2_bytes);
        return 1 << (l2_bytes + 3);
    endfunction

    function automatic int idx_bits(input int l2_cache, input int l2_block);
        return l2_cache - l2_block;
    endfunction

    function automatic int tag_bits(input int l2_addr, input int l2_cache, input int l2_block);
        return l2_addr - idx_bits(l2_cache, l2_block) - l2_block;
    endfunction

    // Derived constants for the default configuration (16-byte cache, 4-byte lines, 16-bit words).
    localparam int BLK = blk_bits(2);
    localparam int DW  = blk_bits(1);
    localparam int OFF = 2;
    localparam int IDX = idx_bits(4, 2);
    localparam int TAG = tag_bits(32, 4, 2);

endpackage

// File: rtl/instruction_cache_control.sv
// rtl/instruction_cache_control.sv - IDLE/COMPARE/MISS/HIT controller for the instruction cache
// Ports: clk, rst (sync active-high); cyc_i/stb_i requester handshake; hit from tag compare;
//        ack_i memory acknowledge; mem_cyc/mem_stb memory request; ack_o requester acknowledge;
//        cache_WE_O line fill strobe.
module instruction_cache_control
    import instruction_cache_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cyc_i,
    input  logic stb_i,
    input  logic hit,
    input  logic ack_i,
    output logic mem_cyc,
    output logic mem_stb,
    output logic ack_o,
    output logic cache_WE_O
);

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are forced low while rst is high, even if the state register
    // still holds MISS/HIT from before the reset edge.
    always_comb begin
        state_next = state;
        mem_cyc    = 1'b0;
        mem_stb    = 1'b0;
        ack_o      = 1'b0;
        cache_WE_O = 1'b0;
        case (state)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                state_next = hit ? HIT : MISS;
            end
            MISS: begin
                mem_cyc    = !rst;
                mem_stb    = !rst;
                cache_WE_O = ack_i && !rst;
                if (ack_i) begin
                    state_next = HIT;
                end
            end
            HIT: begin
                ack_o      = !rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/instruction_cache_path.sv
// rtl/instruction_cache_path.sv - direct-mapped data/tag/valid arrays with combinational word read
// Ports: clk, rst (clears valid bits only); we line fill strobe; adr requested address;
//        fill_data block from memory; dat_o selected word; hit valid && tag match.
module instruction_cache_path
    import instruction_cache_pkg::*;
#(
    parameter int L2_CACHE_SIZE = 4,
    parameter int L2_BLOCK_SIZE = 2,
    parameter int L2_ADDR_SIZE  = 32,
    parameter int L2_DATA_SIZE  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [L2_ADDR_SIZE-1:0]  adr,
    input  logic [blk_bits(L2_BLOCK_SIZE)-1:0] fill_data,
    output logic [blk_bits(L2_DATA_SIZE)-1:0]  dat_o,
    output logic                     hit
);

    localparam int BLK_W = blk_bits(L2_BLOCK_SIZE);
    localparam int DW_W  = blk_bits(L2_DATA_SIZE);
    localparam int OFF_W = L2_BLOCK_SIZE;
    localparam int IDX_W = idx_bits(L2_CACHE_SIZE, L2_BLOCK_SIZE);
    localparam int TAG_W = tag_bits(L2_ADDR_SIZE, L2_CACHE_SIZE, L2_BLOCK_SIZE);
    localparam int LINES = 1 << IDX_W;

    logic [BLK_W-1:0] cache_data [LINES];
    logic [TAG_W-1:0] cache_tag  [LINES];
    logic [LINES-1:0] cache_valid;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             unused_byte_bits;

    assign tag = adr[L2_ADDR_SIZE-1:IDX_W+OFF_W];
    assign idx = adr[IDX_W+OFF_W-1:OFF_W];
    assign unused_byte_bits = ^adr[L2_DATA_SIZE-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= '0;
        end else if (we) begin
            cache_valid[idx] <= 1'b1;
        end
    end

    // Data and tag are intentionally left unreset; the valid bit alone gates hits.
    always_ff @(posedge clk) begin
        if (we) begin
            cache_data[idx] <= fill_data;
            cache_tag[idx]  <= tag;
        end
    end

    assign hit = cache_valid[idx] && (cache_tag[idx] == tag);

    generate
        if (OFF_W > L2_DATA_SIZE) begin : g_word_sel
            logic [OFF_W-L2_DATA_SIZE-1:0] ws;
            assign ws    = adr[OFF_W-1:L2_DATA_SIZE];
            assign dat_o = cache_data[idx][ws*DW_W +: DW_W];
        end else begin : g_single_word
            assign dat_o = cache_data[idx][DW_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache (top)
// Ports: CLK_I, RST_I (sync active-high); inst_* memory side (CYC/STB/ADR out, DAT/ACK in);
//        inst_cache_* requester side (CYC/STB/ADR in, DAT/ACK out).
// Optional: define INSTRUCTION_CACHE_CHECKS_EN for simulation-only protocol assertions.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int L2_CACHE_SIZE = 4,
    parameter int L2_BLOCK_SIZE = 2,
    parameter int L2_ADDR_SIZE  = 32,
    parameter int L2_DATA_SIZE  = 1
) (
    input  logic                               CLK_I,
    input  logic                               RST_I,
    input  logic [blk_bits(L2_BLOCK_SIZE)-1:0] inst_DAT_I,
    input  logic                               inst_ACK_I,
    output logic                               inst_CYC_O,
    output logic                               inst_STB_O,
    output logic [L2_ADDR_SIZE-1:0]            inst_ADR_O,
    input  logic                               inst_cache_CYC_I,
    input  logic                               inst_cache_STB_I,
    input  logic [L2_ADDR_SIZE-1:0]            inst_cache_ADR_I,
    output logic [blk_bits(L2_DATA_SIZE)-1:0]  inst_cache_DAT_O,
    output logic                               inst_cache_ACK_O
);

    localparam int OFF_W = L2_BLOCK_SIZE;

    logic hit;
    logic cache_we;

    // Refill always fetches the whole line, so the offset bits are zeroed.
    assign inst_ADR_O = {inst_cache_ADR_I[L2_ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}};

    instruction_cache_control control (
        .clk        (CLK_I),
        .rst        (RST_I),
        .cyc_i      (inst_cache_CYC_I),
        .stb_i      (inst_cache_STB_I),
        .hit        (hit),
        .ack_i      (inst_ACK_I),
        .mem_cyc    (inst_CYC_O),
        .mem_stb    (inst_STB_O),
        .ack_o      (inst_cache_ACK_O),
        .cache_WE_O (cache_we)
    );

    instruction_cache_path #(
        .L2_CACHE_SIZE (L2_CACHE_SIZE),
        .L2_BLOCK_SIZE (L2_BLOCK_SIZE),
        .L2_ADDR_SIZE  (L2_ADDR_SIZE),
        .L2_DATA_SIZE  (L2_DATA_SIZE)
    ) path (
        .clk       (CLK_I),
        .rst       (RST_I),
        .we        (cache_we),
        .adr       (inst_cache_ADR_I),
        .fill_data (inst_DAT_I),
        .dat_o     (inst_cache_DAT_O),
        .hit       (hit)
    );

`ifdef INSTRUCTION_CACHE_CHECKS_EN
    a_ack_only_in_miss: assert property (@(posedge CLK_I) disable iff (RST_I)
        inst_ACK_I |-> inst_CYC_O)
        else $error("inst_ACK_I asserted outside MISS");

    // MISS/HIT are only reachable from COMPARE/MISS, so the address must match the previous edge.
    a_adr_stable: assert property (@(posedge CLK_I) disable iff (RST_I)
        (control.state inside {MISS, HIT}) |-> $stable(inst_cache_ADR_I))
        else $error("inst_cache_ADR_I changed during a transaction");
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - scoreboard bench for instruction_cache
module tb_instruction_cache;
    import instruction_cache_pkg::*;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [31:0] inst_DAT_I;
    logic        inst_ACK_I;
    logic        inst_CYC_O;
    logic        inst_STB_O;
    logic [31:0] inst_ADR_O;
    logic        inst_cache_CYC_I;
    logic        inst_cache_STB_I;
    logic [31:0] inst_cache_ADR_I;
    logic [15:0] inst_cache_DAT_O;
    logic        inst_cache_ACK_O;

    instruction_cache dut (
        .CLK_I            (CLK_I),
        .RST_I            (RST_I),
        .inst_DAT_I       (inst_DAT_I),
        .inst_ACK_I       (inst_ACK_I),
        .inst_CYC_O       (inst_CYC_O),
        .inst_STB_O       (inst_STB_O),
        .inst_ADR_O       (inst_ADR_O),
        .inst_cache_CYC_I (inst_cache_CYC_I),
        .inst_cache_STB_I (inst_cache_STB_I),
        .inst_cache_ADR_I (inst_cache_ADR_I),
        .inst_cache_DAT_O (inst_cache_DAT_O),
        .inst_cache_ACK_O (inst_cache_ACK_O)
    );

    always #5 CLK_I = ~CLK_I;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q [$];

    bit          vm [4];
    logic [27:0] tm [4];
    logic [31:0] dm [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every requester acknowledge consumes one expected word.
    always @(negedge CLK_I) begin
        if (inst_cache_ACK_O === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("dat_o", inst_cache_DAT_O, e);
            end
        end
    end

    // want < 0: expected word comes from the reference model; otherwise it is hand-computed.
    task automatic do_read(input logic [31:0] a, input logic [31:0] mem, input int ack_delay,
                           input bit drop, input int want);
        logic [1:0]  idx;
        logic [27:0] tg;
        bit hit, done, acked, exp_cyc, exp_ack;
        int edges, ack_edge, waited;
        idx = a[3:2];
        tg  = a[31:4];
        hit = vm[idx] && (tm[idx] == tg);
        if (!hit) begin
            vm[idx] = 1'b1;
            tm[idx] = tg;
            dm[idx] = mem;
        end
        if (want < 0) exp_q.push_back(a[1] ? dm[idx][31:16] : dm[idx][15:0]);
        else          exp_q.push_back(want[15:0]);
        inst_cache_ADR_I = a;
        inst_cache_CYC_I = 1'b1;
        inst_cache_STB_I = 1'b1;
        edges = 0; ack_edge = -10; waited = 0; done = 0; acked = 0;
        while (!done && edges < 40) begin
            @(posedge CLK_I);
            edges++;
            @(negedge CLK_I);
            if (drop && edges == 1) begin
                inst_cache_CYC_I = 1'b0;
                inst_cache_STB_I = 1'b0;
            end
            exp_cyc = !hit && edges >= 2 && !acked;
            check("cyc_o", inst_CYC_O, exp_cyc);
            check("stb_o", inst_STB_O, exp_cyc);
            inst_ACK_I = 1'b0;
            if (exp_cyc) begin
                check("adr_o", inst_ADR_O, {a[31:2], 2'b00});
                if (waited >= ack_delay) begin
                    inst_ACK_I = 1'b1;
                    inst_DAT_I = mem;
                    acked      = 1'b1;
                    ack_edge   = edges;
                end else begin
                    inst_DAT_I = $urandom;
                    waited++;
                end
            end
            #1;
            check("we", dut.control.cache_WE_O, exp_cyc && inst_ACK_I);
            exp_ack = hit ? (edges == 2) : (acked && edges == ack_edge + 1);
            check("ack_o", inst_cache_ACK_O, exp_ack);
            if (inst_cache_ACK_O === 1'b1) done = 1'b1;
        end
        if (!done) check("ack_timeout", 0, 1);
        check("valid_line", dut.path.cache_valid[idx], 1);
        check("tag_line", dut.path.cache_tag[idx], tg);
        inst_ACK_I       = 1'b0;
        inst_cache_CYC_I = 1'b0;
        inst_cache_STB_I = 1'b0;
        @(posedge CLK_I);
        #1;
    endtask

    initial begin
        RST_I = 1'b1;
        inst_DAT_I = '0;
        inst_ACK_I = 1'b0;
        inst_cache_CYC_I = 1'b0;
        inst_cache_STB_I = 1'b0;
        inst_cache_ADR_I = '0;
        for (int i = 0; i < 4; i++) vm[i] = 1'b0;

        repeat (3) @(posedge CLK_I);
        @(negedge CLK_I);
        check("rst_ack_o", inst_cache_ACK_O, 0);
        check("rst_cyc_o", inst_CYC_O, 0);
        check("rst_stb_o", inst_STB_O, 0);
        check("rst_valid", dut.path.cache_valid, 4'h0);
        check("rst_state", dut.control.state, IDLE);
        RST_I = 1'b0;
        @(posedge CLK_I);
        #1;

        // Directed: miss fill, hit on other word, conflict replacement.
        do_read(32'h16, 32'hAAAA5555, 0, 0, 16'hAAAA);
        check("tag1_after_fill", dut.path.cache_tag[1], 28'h1);
        do_read(32'h14, 32'hDEADBEEF, 0, 0, 16'h5555);
        do_read(32'h24, 32'h12345678, 0, 1, 16'h5678);
        check("tag1_replaced", dut.path.cache_tag[1], 28'h2);
        do_read(32'h26, 32'h0, 0, 0, 16'h1234);

        // CYC without STB: no transaction, DAT_O still follows the array.
        inst_cache_ADR_I = 32'h26;
        inst_cache_CYC_I = 1'b1;
        inst_cache_STB_I = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_I);
            check("idle_ack_o", inst_cache_ACK_O, 0);
            check("idle_cyc_o", inst_CYC_O, 0);
            check("idle_we", dut.control.cache_WE_O, 0);
            check("idle_dat_o", inst_cache_DAT_O, 16'h1234);
        end
        inst_cache_CYC_I = 1'b0;
        @(posedge CLK_I);
        #1;

        // Reset while waiting for memory.
        inst_cache_ADR_I = 32'h36;
        inst_cache_CYC_I = 1'b1;
        inst_cache_STB_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        @(negedge CLK_I);
        check("miss_cyc_before_rst", inst_CYC_O, 1);
        RST_I = 1'b1;
        #1;
        check("cyc_during_rst", inst_CYC_O, 0);
        inst_cache_CYC_I = 1'b0;
        inst_cache_STB_I = 1'b0;
        @(posedge CLK_I);
        @(negedge CLK_I);
        check("cyc_after_rst", inst_CYC_O, 0);
        check("valid_after_rst", dut.path.cache_valid, 4'h0);
        check("state_after_rst", dut.control.state, IDLE);
        RST_I = 1'b0;
        for (int i = 0; i < 4; i++) vm[i] = 1'b0;
        @(posedge CLK_I);
        #1;

        // Random regression against the reference model.
        for (int n = 0; n < 10000; n++) begin
            logic [31:0] a;
            logic [1:0]  tsel;
            logic [3:0]  low;
            tsel = 2'($urandom_range(0, 3));
            low  = 4'($urandom_range(0, 15));
            a    = {1'($urandom_range(0, 1)), 25'h0, tsel, low};
            do_read(a, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
        end

        if (exp_q.size() != 0) check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 The module SHALL have parameter L2_CACHE_SIZE, default 4, meaning log2 of cache capacity in bytes.
REQ-002 The module SHALL have parameter L2_BLOCK_SIZE, default 2, meaning log2 of block (line) size in bytes.
REQ-003 The module SHALL have parameter L2_ADDR_SIZE, default 32, meaning address width in bits.
REQ-004 The module SHALL have parameter L2_DATA_SIZE, default 1, meaning log2 of returned word size in bytes.
REQ-005 Derived widths SHALL be:
- BLK = 2**(L2_BLOCK_SIZE+3); DW = 2**(L2_DATA_SIZE+3).
- OFF = L2_BLOCK_SIZE; IDX = L2_CACHE_SIZE-L2_BLOCK_SIZE; TAG = L2_ADDR_SIZE-IDX-OFF.
REQ-006 There SHALL be one clock; reset is synchronous and active-high.
REQ-007 Ports (name  direction  width  meaning):
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous active-high reset.
- inst_DAT_I  in  BLK  block returned by instruction memory.
- inst_ACK_I  in  1  memory acknowledge.
- inst_CYC_O  out  1  memory cycle request.
- inst_STB_O  out  1  memory strobe.
- inst_ADR_O  out  L2_ADDR_SIZE  memory address.
- inst_cache_CYC_I  in  1  requester cycle.
- inst_cache_STB_I  in  1  requester strobe.
- inst_cache_ADR_I  in  L2_ADDR_SIZE  requested address.
- inst_cache_DAT_O  out  DW  returned word.
- inst_cache_ACK_O  out  1  requester acknowledge.

Function
REQ-008 The cache SHALL be direct-mapped and read-only, with 2**IDX lines, each holding a BLK data field, a TAG field and a valid bit.
REQ-009 Address split SHALL be: tag = ADR[L2_ADDR_SIZE-1:IDX+OFF]; index = ADR[IDX+OFF-1:OFF]; word select = ADR[OFF-1:L2_DATA_SIZE]; byte bits are ignored.
REQ-010 inst_cache_DAT_O SHALL be combinational at all times and SHALL equal line[index] data bits [(ws+1)*DW-1 -: DW]; when L2_BLOCK_SIZE equals L2_DATA_SIZE, ws is 0.
REQ-011 The FSM SHALL have the states IDLE, COMPARE, MISS and HIT, with Moore outputs.
REQ-012 In IDLE, the FSM SHALL move to COMPARE when inst_cache_CYC_I and inst_cache_STB_I are both 1; otherwise it SHALL stay in IDLE.
REQ-013 In COMPARE, the FSM SHALL move to HIT if valid[index] is 1 and the stored tag equals the address tag; otherwise it SHALL move to MISS.
REQ-014 In MISS:
- inst_CYC_O and inst_STB_O SHALL be 1.
- inst_ADR_O SHALL be {tag, index, OFF zeros}.
- The FSM SHALL wait for inst_ACK_I.
REQ-015 cache_WE_O SHALL equal (state==MISS and inst_ACK_I).
- On the edge where cache_WE_O is 1, line[index] SHALL be written: data := inst_DAT_I, tag := address tag, valid := 1.
- On that same edge, the FSM SHALL move to HIT.
REQ-016 In HIT, inst_cache_ACK_O SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-017 Latency SHALL be: on a hit, ACK_O is asserted on the 2nd rising edge after the request is sampled; on a miss, ACK_O is asserted the cycle after inst_ACK_I is sampled.
REQ-018 Outside MISS, inst_CYC_O, inst_STB_O and cache_WE_O SHALL be 0; outside HIT, inst_cache_ACK_O SHALL be 0.
REQ-019 The requester SHALL hold its address stable until ACK_O; a drop of CYC/STB after IDLE does not abort the transaction.

Reset
REQ-020 On RST_I, the FSM SHALL enter IDLE and all valid bits SHALL clear, including when reset occurs mid-MISS.
REQ-021 While in reset, all control outputs SHALL be 0.
REQ-022 The data and tag arrays SHALL NOT be reset or initialised; they read X until first fill.

Configuration
REQ-023 With macro INSTRUCTION_CACHE_CHECKS_EN defined, the design SHALL include simulation-only assertions that flag:
- inst_ACK_I high outside MISS;
- inst_cache_ADR_I changing between COMPARE and HIT.
REQ-024 Without INSTRUCTION_CACHE_CHECKS_EN, no assertion logic SHALL be present and function SHALL be identical.

Structure
REQ-025 The state encoding and derived width constants (BLK, DW, OFF, IDX, TAG) SHALL live in a shared package/header.
REQ-026 The design SHALL contain two instances:
- instance "control" of sub-module instruction_cache_control: the FSM, with output cache_WE_O.
- instance "path": holding the arrays cache_data, cache_tag and cache_valid, hierarchically visible to benches.

Verification (defaults: 4 lines, 4-byte blocks, 16-bit words)
REQ-027 After reset, read 0x16 (index 1, tag 1, ws 1):
- CYC/STB SHALL be 1 from the 2nd edge, with ADR_O=0x14.
- For ACK_I with DAT_I=0xAAAA5555: next cycle ACK_O=1, DAT_O=0xAAAA, valid[1]=1, tag[1]=1, CYC/STB=0.
REQ-028 Then read 0x14: ACK_O=1 on the 2nd edge, DAT_O=0x5555, and CYC_O SHALL never rise.
REQ-029 Then read 0x24 (index 1, tag 2): a miss SHALL occur, and the refill SHALL replace line 1 with tag[1]=2.
REQ-030 CYC_I=1, STB_I=0 held 5 cycles: ACK_O, CYC_O and cache_WE_O SHALL stay 0, while DAT_O SHALL still track the array.
REQ-031 RST_I pulsed during MISS: the next cycle SHALL show CYC_O=0, all valid bits=0 and the FSM in IDLE.
REQ-032 A 10000-iteration random regression against a reference model SHALL check DAT_O, ACK_O, CYC/STB, cache_WE_O, tag and valid.
